// File: rtl/clarvi_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : clarvi_regfile_sequencer
// Brief   : Byte-serial read/write sequencer between execute and the 64-bit
//           Clarvi register file's 8-bit part interface.
// Revision: 1.0 - initial release
// ============================================================================
module clarvi_regfile_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata1,
    output logic [63:0] resp_rdata2,
    output logic [4:0]  rf_fetch_register_1,
    output logic [4:0]  rf_fetch_register_2,
    output logic [2:0]  rf_fetch_part,
    output logic        rf_rs2_part_override,
    input  logic [7:0]  rf_data_out_1,
    input  logic [7:0]  rf_data_out_2,
    output logic [4:0]  rf_write_register,
    output logic [2:0]  rf_write_part,
    output logic [7:0]  rf_data_in,
    output logic        rf_write_enable
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_part;
    logic        r_word;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata1;
    logic [63:0] r_rdata2;
    logic        w_last_read;
    logic [5:0]  w_lane;

    assign w_last_read = (r_part == (r_word ? 3'd3 : 3'd7));
    assign w_lane      = {r_part, 3'b000};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_state_next = req_write ? ST_WRITE : ST_READ;
            ST_READ:  if (w_last_read) w_state_next = ST_RESP;
            ST_WRITE: if (r_part == 3'd7) w_state_next = ST_RESP;
            ST_RESP:  if (resp_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_part   <= 3'd0;
            r_word   <= 1'b0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_rd     <= 5'd0;
            r_wdata  <= 64'd0;
            r_rdata1 <= 64'd0;
            r_rdata2 <= 64'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_part <= 3'd0;
                        r_word <= req_word;
                        r_rs1  <= req_rs1;
                        r_rs2  <= req_rs2;
                        r_rd   <= req_rd;
                        r_wdata <= req_word ? {{32{req_wdata[31]}}, req_wdata[31:0]}
                                            : req_wdata;
                        if (req_write) begin
                            r_rdata1 <= 64'd0;
                            r_rdata2 <= 64'd0;
                        end
                    end
                end
                ST_READ: begin
                    r_rdata1[w_lane +: 8] <= rf_data_out_1;
                    r_rdata2[w_lane +: 8] <= rf_data_out_2;
                    // Word reads sign-fill the upper half on the same edge as byte 3.
                    if (r_word && w_last_read) begin
                        r_rdata1[63:32] <= {32{rf_data_out_1[7]}};
                        r_rdata2[63:32] <= {32{rf_data_out_2[7]}};
                    end
                    r_part <= r_part + 3'd1;
                end
                ST_WRITE: r_part <= r_part + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready            = (r_state == ST_IDLE);
        resp_valid           = (r_state == ST_RESP);
        rf_rs2_part_override = 1'b0;
        rf_fetch_register_1  = 5'd0;
        rf_fetch_register_2  = 5'd0;
        rf_fetch_part        = 3'd0;
        rf_write_register    = 5'd0;
        rf_write_part        = 3'd0;
        rf_data_in           = 8'd0;
        rf_write_enable      = 1'b0;
        if (r_state == ST_READ) begin
            rf_fetch_register_1 = r_rs1;
            rf_fetch_register_2 = r_rs2;
            rf_fetch_part       = r_part;
        end
        if (r_state == ST_WRITE) begin
            rf_write_register = r_rd;
            rf_write_part     = r_part;
            rf_data_in        = r_wdata[w_lane +: 8];
            // x0 still walks all parts but never strobes.
            rf_write_enable   = (r_rd != 5'd0);
        end
    end

    assign resp_rdata1 = r_rdata1;
    assign resp_rdata2 = r_rdata2;

endmodule
`default_nettype wire

// File: tb/tb_clarvi_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_clarvi_regfile_sequencer
// Brief   : Self-checking bench: vector table, reset/backpressure sequences and
//           random operations against a register-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clarvi_regfile_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_word = 1'b0;
    logic [4:0]  req_rs1 = 5'd0;
    logic [4:0]  req_rs2 = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata1;
    logic [63:0] resp_rdata2;
    logic [4:0]  rf_fetch_register_1;
    logic [4:0]  rf_fetch_register_2;
    logic [2:0]  rf_fetch_part;
    logic        rf_rs2_part_override;
    logic [7:0]  rf_data_out_1;
    logic [7:0]  rf_data_out_2;
    logic [4:0]  rf_write_register;
    logic [2:0]  rf_write_part;
    logic [7:0]  rf_data_in;
    logic        rf_write_enable;

    clarvi_regfile_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2),
        .rf_fetch_register_1(rf_fetch_register_1), .rf_fetch_register_2(rf_fetch_register_2),
        .rf_fetch_part(rf_fetch_part), .rf_rs2_part_override(rf_rs2_part_override),
        .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2),
        .rf_write_register(rf_write_register), .rf_write_part(rf_write_part),
        .rf_data_in(rf_data_in), .rf_write_enable(rf_write_enable)
    );

    always #5 clock = ~clock;

    // Register file environment: combinational byte reads, byte writes on strobe.
    logic [63:0] rf_mem [32] = '{default: 64'd0};
    assign rf_data_out_1 = rf_mem[rf_fetch_register_1][{rf_fetch_part, 3'b000} +: 8];
    assign rf_data_out_2 = rf_mem[rf_fetch_register_2][{rf_fetch_part, 3'b000} +: 8];
    always @(posedge clock)
        if (rf_write_enable) rf_mem[rf_write_register][{rf_write_part, 3'b000} +: 8] <= rf_data_in;

    // Architectural reference: whole-register values after each completed operation.
    logic [63:0] model_regs [32] = '{default: 64'd0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic rf_outputs_idle();
        return (rf_fetch_register_1 == 5'd0) && (rf_fetch_register_2 == 5'd0) &&
               (rf_fetch_part == 3'd0) && (rf_rs2_part_override == 1'b0) &&
               (rf_write_register == 5'd0) && (rf_write_part == 3'd0) &&
               (rf_data_in == 8'd0) && (rf_write_enable == 1'b0);
    endfunction

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // One complete request/response transaction; called at a negedge while idle.
    task automatic run_op(input logic wr, input logic word, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] wdata,
                          input logic [63:0] e1, input logic [63:0] e2, input int elat,
                          input int hold, input string tag);
        int cyc = 0;
        int strobes = 0;
        int nparts;
        logic ok = 1'b1;
        logic seen = 1'b0;
        logic stable = 1'b1;
        logic [63:0] ext;
        logic [63:0] d1;
        logic [63:0] d2;
        ext    = word ? sext32(wdata) : wdata;
        nparts = (!wr && word) ? 4 : 8;
        req_valid = 1'b1; req_write = wr; req_word = word;
        req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wdata = wdata;
        resp_ready = (hold == 0);
        check({tag, ".ready_before"}, 64'(req_ready), 64'd1);
        @(posedge clock);
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            req_valid = 1'b0;
            if (resp_valid) seen = 1'b1;
            else begin
                if (req_ready) ok = 1'b0;
                if (cyc > nparts) ok = 1'b0;
                else if (wr) begin
                    if (rf_write_part != 3'(cyc - 1)) ok = 1'b0;
                    if (rf_data_in != ext[(cyc - 1) * 8 +: 8]) ok = 1'b0;
                    if (rf_write_enable != (rd != 5'd0)) ok = 1'b0;
                    if (rf_write_register != rd) ok = 1'b0;
                    if (rf_fetch_part != 3'd0) ok = 1'b0;
                    if (rf_write_enable) strobes++;
                end else begin
                    if (rf_fetch_part != 3'(cyc - 1)) ok = 1'b0;
                    if (rf_fetch_register_1 != rs1 || rf_fetch_register_2 != rs2) ok = 1'b0;
                    if (rf_write_enable || rf_write_part != 3'd0) ok = 1'b0;
                end
            end
        end
        check({tag, ".latency"}, seen ? 64'(cyc) : 64'hFFFF, 64'(elat));
        check({tag, ".sequence"}, 64'(ok), 64'd1);
        check({tag, ".strobes"}, 64'(strobes), (wr && rd != 5'd0) ? 64'd8 : 64'd0);
        d1 = resp_rdata1;
        d2 = resp_rdata2;
        check({tag, ".rdata1"}, d1, e1);
        check({tag, ".rdata2"}, d2, e2);
        check({tag, ".resp_idle"}, 64'(rf_outputs_idle() && !req_ready), 64'd1);
        for (int h = 1; h < hold; h++) begin
            @(negedge clock);
            if (!resp_valid || req_ready || resp_rdata1 != d1 || resp_rdata2 != d2) stable = 1'b0;
        end
        if (hold > 0) check({tag, ".backpressure"}, 64'(stable), 64'd1);
        resp_ready = 1'b1;
        @(negedge clock);
        check({tag, ".ready_after"}, {62'd0, req_ready, resp_valid}, 64'd2);
        if (wr && rd != 5'd0) model_regs[rd] = ext;
    endtask

    typedef struct {
        logic        wr;
        logic        word;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [63:0] e1;
        logic [63:0] e2;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 64'h0123456789ABCDEF, 64'd0, 64'd0, 9, 0};
        vecs[1] = '{1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 64'd0, 64'h0123456789ABCDEF, 64'd0, 9, 0};
        vecs[2] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 64'h0000000080000001, 64'd0, 64'd0, 9, 0};
        vecs[3] = '{1'b0, 1'b0, 5'd6, 5'd5, 5'd0, 64'd0, 64'hFFFFFFFF80000001,
                    64'h0123456789ABCDEF, 9, 2};
        vecs[4] = '{1'b0, 1'b1, 5'd5, 5'd6, 5'd0, 64'd0, 64'hFFFFFFFF89ABCDEF,
                    64'hFFFFFFFF80000001, 5, 0};
        vecs[5] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 64'hDEADBEEFCAFEF00D, 64'd0, 64'd0, 9, 3};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 64'd0, 64'd0, 64'h0123456789ABCDEF, 9, 0};

        repeat (2) @(negedge clock);
        check("reset.handshake", {62'd0, req_ready, resp_valid}, 64'd2);
        check("reset.rdata", resp_rdata1 | resp_rdata2, 64'd0);
        check("reset.rf_idle", 64'(rf_outputs_idle()), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].wr, vecs[i].word, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].wdata, vecs[i].e1, vecs[i].e2, vecs[i].lat, vecs[i].hold,
                   $sformatf("vec%0d", i));

        // Reset during a write: three bytes land, the rest of x7 keeps its old value.
        run_op(1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 64'h1111111111111111, 64'd0, 64'd0, 9, 0, "x7init");
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0; req_rd = 5'd7;
        req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset.strobe_before", 64'(rf_write_enable), 64'd1);
        reset = 1'b1;
        #1;
        check("midreset.handshake", {62'd0, req_ready, resp_valid}, 64'd2);
        check("midreset.rf_idle", 64'(rf_outputs_idle()), 64'd1);
        check("midreset.rdata", resp_rdata1 | resp_rdata2, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        model_regs[7] = 64'h1111111111AAAAAA;
        run_op(1'b0, 1'b0, 5'd7, 5'd6, 5'd0, 64'd0, 64'h1111111111AAAAAA,
               64'hFFFFFFFF80000001, 9, 0, "midreset.read");

        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic        word;
            logic [4:0]  rs1;
            logic [4:0]  rs2;
            logic [4:0]  rd;
            logic [63:0] wdata;
            logic [63:0] e1;
            logic [63:0] e2;
            int          lat;
            int          hold;
            wr    = 1'($urandom_range(0, 1));
            word  = 1'($urandom_range(0, 1));
            rs1   = 5'($urandom_range(0, 9));
            rs2   = 5'($urandom_range(0, 9));
            rd    = 5'($urandom_range(0, 9));
            wdata = {$urandom, $urandom};
            hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (wr) begin
                e1 = 64'd0; e2 = 64'd0; lat = 9;
            end else begin
                e1  = word ? sext32(model_regs[rs1]) : model_regs[rs1];
                e2  = word ? sext32(model_regs[rs2]) : model_regs[rs2];
                lat = word ? 5 : 9;
            end
            run_op(wr, word, rs1, rs2, rd, wdata, e1, e2, lat, hold, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
